// File: rtl/timer_regs_pkg.sv
// Shared constants for the APB timer register block: register offsets, TSR bit positions, FSM states.
package timer_regs_pkg;

    localparam logic [1:0] OFS_TDR = 2'd0;
    localparam logic [1:0] OFS_TCR = 2'd1;
    localparam logic [1:0] OFS_TSR = 2'd2;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_e;

endpackage

// File: rtl/timer_ch_regs.sv
// One timer channel's TDR/TCR/TSR: TCR writes are masked, TSR is write-1-to-clear with hardware set.
// Updates land on the commit edge; a hardware set wins over a same-cycle software clear.
module timer_ch_regs
    import timer_regs_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] TCR_MASK   = 'hB3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [1:0]            ofs_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [1:0]            tsr_set_i,
    output logic [DATA_WIDTH-1:0] tdr_o,
    output logic [DATA_WIDTH-1:0] tcr_o,
    output logic [DATA_WIDTH-1:0] tsr_o
);

    logic [DATA_WIDTH-1:0] tdr_q, tdr_d;
    logic [DATA_WIDTH-1:0] tcr_q, tcr_d;
    logic [1:0]            tsr_q, tsr_d;
    logic [1:0]            clr;

    always_comb begin
        tdr_d = tdr_q;
        tcr_d = tcr_q;
        clr   = 2'b00;
        if (wr_en_i && ofs_i == OFS_TDR) tdr_d = wdata_i;
        if (wr_en_i && ofs_i == OFS_TCR) tcr_d = wdata_i & TCR_MASK;
        if (wr_en_i && ofs_i == OFS_TSR) clr = wdata_i[1:0];
        tsr_d          = '0;
        tsr_d[TSR_OVF] = tsr_set_i[0] | (tsr_q[TSR_OVF] & ~clr[TSR_OVF]);
        tsr_d[TSR_UDF] = tsr_set_i[1] | (tsr_q[TSR_UDF] & ~clr[TSR_UDF]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tdr_q <= '0;
            tcr_q <= '0;
            tsr_q <= '0;
        end else begin
            tdr_q <= tdr_d;
            tcr_q <= tcr_d;
            tsr_q <= tsr_d;
        end
    end

    assign tdr_o = tdr_q;
    assign tcr_o = tcr_q;
    assign tsr_o = {{(DATA_WIDTH-2){1'b0}}, tsr_q};

endmodule

// File: rtl/apb_timer_regs.sv
// APB slave register file for NUM_CH timer channels with WAIT_STATES wait cycles; transfer = WAIT_STATES+2 cycles.
// PREADY is held low during wait cycles; APB_PSLVERR_EN enables PSLVERR on invalid addresses.
module apb_timer_regs
    import timer_regs_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    NUM_CH      = 4,
    parameter int                    WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] TCR_MASK    = 'hB3
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_CH*DATA_WIDTH-1:0] TDR,
    output logic [NUM_CH*DATA_WIDTH-1:0] TCR,
    output logic [NUM_CH*DATA_WIDTH-1:0] TSR,
    output logic [NUM_CH-1:0]            tdr_wr,
    input  logic [2*NUM_CH-1:0]          tsr_set
);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [NUM_CH-1:0]       tdr_wr_q, tdr_wr_d;
    logic [NUM_CH-1:0]       ch_wr_en;
    logic [1:0]              ofs;
    logic [ADDR_WIDTH-3:0]   ch_idx;
    logic                    addr_err;
    logic                    commit;
    logic [DATA_WIDTH-1:0]   rd_data;

    // Decode works from the address captured at setup so PRDATA never depends on live PADDR.
    assign ofs      = addr_q[1:0];
    assign ch_idx   = addr_q[ADDR_WIDTH-1:2];
    assign addr_err = (ofs == 2'd3) || (int'(ch_idx) >= NUM_CH);
    assign commit   = (state_q == READY) && PSEL && PENABLE && PWRITE && !addr_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    if (WAIT_STATES == 0) begin
                        state_d = READY;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            tdr_wr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            tdr_wr_q <= tdr_wr_d;
        end
    end

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            assign ch_wr_en[c] = commit && (int'(ch_idx) == c);
            assign tdr_wr_d[c] = ch_wr_en[c] && (ofs == OFS_TDR);

            timer_ch_regs #(
                .DATA_WIDTH (DATA_WIDTH),
                .TCR_MASK   (TCR_MASK)
            ) u_ch (
                .clk_i     (PCLK),
                .rst_i     (PRESET),
                .wr_en_i   (ch_wr_en[c]),
                .ofs_i     (ofs),
                .wdata_i   (PWDATA),
                .tsr_set_i (tsr_set[2*c +: 2]),
                .tdr_o     (TDR[c*DATA_WIDTH +: DATA_WIDTH]),
                .tcr_o     (TCR[c*DATA_WIDTH +: DATA_WIDTH]),
                .tsr_o     (TSR[c*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        if (state_q == READY && !write_q && !addr_err) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(ch_idx) == i) begin
                    case (ofs)
                        OFS_TDR: rd_data = TDR[i*DATA_WIDTH +: DATA_WIDTH];
                        OFS_TCR: rd_data = TCR[i*DATA_WIDTH +: DATA_WIDTH];
                        OFS_TSR: rd_data = TSR[i*DATA_WIDTH +: DATA_WIDTH];
                        default: rd_data = '0;
                    endcase
                end
            end
        end
    end

    assign PRDATA = rd_data;
    assign PREADY = (state_q == READY);
    assign tdr_wr = tdr_wr_q;

`ifdef APB_PSLVERR_EN
    assign PSLVERR = (state_q == READY) && addr_err;
`else
    assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_timer_regs.sv
// Directed bench for apb_timer_regs: one WAIT_STATES=1 instance for function, WAIT_STATES=0/3 instances for latency.
module tb_apb_timer_regs;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [7:0]  PWDATA;
    logic [7:0]  tsr_set;
    logic [2:0]  psel_v;
    logic [2:0]  penable_v;
    logic [2:0]  pready_v;
    logic [2:0]  pslverr_v;
    logic [7:0]  prdata_v [3];
    logic [31:0] tdr_v [3];
    logic [31:0] tcr_v [3];
    logic [31:0] tsr_v [3];
    logic [3:0]  tdr_wr_v [3];

    int n_checks = 0;
    int n_errors = 0;

`ifdef APB_PSLVERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 PCLK = ~PCLK;

    apb_timer_regs #(.WAIT_STATES(1)) u_dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_v[0]), .PENABLE(penable_v[0]), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_v[0]), .PREADY(pready_v[0]), .PSLVERR(pslverr_v[0]),
        .TDR(tdr_v[0]), .TCR(tcr_v[0]), .TSR(tsr_v[0]), .tdr_wr(tdr_wr_v[0]), .tsr_set(tsr_set)
    );

    apb_timer_regs #(.WAIT_STATES(0)) u_ws0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_v[1]), .PENABLE(penable_v[1]), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_v[1]), .PREADY(pready_v[1]), .PSLVERR(pslverr_v[1]),
        .TDR(tdr_v[1]), .TCR(tcr_v[1]), .TSR(tsr_v[1]), .tdr_wr(tdr_wr_v[1]), .tsr_set(tsr_set)
    );

    apb_timer_regs #(.WAIT_STATES(3)) u_ws3 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_v[2]), .PENABLE(penable_v[2]), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_v[2]), .PREADY(pready_v[2]), .PSLVERR(pslverr_v[2]),
        .TDR(tdr_v[2]), .TCR(tcr_v[2]), .TSR(tsr_v[2]), .tdr_wr(tdr_wr_v[2]), .tsr_set(tsr_set)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one APB transfer on instance d; returns at the negedge of the PREADY cycle with the bus still driven.
    task automatic apb(input int d, input logic [7:0] a, input logic w, input logic [7:0] wd,
                       output logic [7:0] rd, output logic err, output int cyc);
        @(negedge PCLK);
        psel_v    = '0;
        penable_v = '0;
        psel_v[d] = 1'b1;
        PADDR     = a;
        PWRITE    = w;
        PWDATA    = wd;
        cyc       = 1;
        @(negedge PCLK);
        penable_v[d] = 1'b1;
        cyc          = 2;
        while (!pready_v[d] && cyc < 30) begin
            @(negedge PCLK);
            cyc++;
        end
        rd  = prdata_v[d];
        err = pslverr_v[d];
    endtask

    task automatic bus_idle();
        @(negedge PCLK);
        psel_v    = '0;
        penable_v = '0;
        PWRITE    = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       err;
        int         cyc;
        logic       seen_rdy;

        PRESET = 1'b1; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; tsr_set = '0;
        psel_v = '0; penable_v = '0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        check("rst_tdr", tdr_v[0], 32'h0);
        check("rst_tcr", tcr_v[0], 32'h0);
        check("rst_tsr", tsr_v[0], 32'h0);
        check("rst_out", {pready_v[0], pslverr_v[0], prdata_v[0], tdr_wr_v[0]}, 32'h0);

        apb(0, 8'h01, 1'b0, 8'h00, rd, err, cyc);
        check("rd01_cyc", cyc, 3);
        check("rd01_data", rd, 8'h00);
        check("rd01_err", err, 1'b0);

        apb(0, 8'h05, 1'b1, 8'hFF, rd, err, cyc);
        bus_idle();
        check("tcr1_mask", tcr_v[0][15:8], 8'hB3);
        apb(0, 8'h05, 1'b0, 8'h00, rd, err, cyc);
        check("tcr1_rd", rd, 8'hB3);

        // Back-to-back write directly after the read.
        apb(0, 8'h08, 1'b1, 8'h5A, rd, err, cyc);
        check("wr08_cyc", cyc, 3);
        bus_idle();
        check("tdr2", tdr_v[0][23:16], 8'h5A);
        check("tdr_wr_pulse", tdr_wr_v[0], 4'b0100);
        bus_idle();
        check("tdr_wr_low", tdr_wr_v[0], 4'b0000);

        @(negedge PCLK); tsr_set = 8'h01;
        @(negedge PCLK); tsr_set = 8'h00;
        check("tsr0_set", tsr_v[0][7:0], 8'h01);
        apb(0, 8'h02, 1'b0, 8'h00, rd, err, cyc);
        check("tsr0_rd", rd, 8'h01);
        apb(0, 8'h02, 1'b1, 8'h01, rd, err, cyc);
        bus_idle();
        check("tsr0_clr", tsr_v[0][7:0], 8'h00);

        @(negedge PCLK); tsr_set = 8'h08;
        @(negedge PCLK); tsr_set = 8'h00;
        check("tsr1_udf", tsr_v[0][15:8], 8'h02);
        apb(0, 8'h06, 1'b1, 8'h03, rd, err, cyc);
        bus_idle();
        check("tsr1_clr", tsr_v[0][15:8], 8'h00);

        @(negedge PCLK); tsr_set = 8'h01;
        apb(0, 8'h02, 1'b1, 8'h01, rd, err, cyc);
        bus_idle();
        tsr_set = 8'h00;
        check("tsr0_set_wins", tsr_v[0][7:0], 8'h01);

        apb(0, 8'h03, 1'b1, 8'h77, rd, err, cyc);
        check("err03_wr", err, EXP_ERR);
        apb(0, 8'h10, 1'b1, 8'h77, rd, err, cyc);
        check("err10_wr", err, EXP_ERR);
        check("err10_cyc", cyc, 3);
        apb(0, 8'h10, 1'b0, 8'h00, rd, err, cyc);
        check("err10_rd_err", err, EXP_ERR);
        check("err10_rd_data", rd, 8'h00);
        apb(0, 8'h03, 1'b0, 8'h00, rd, err, cyc);
        check("err03_rd_data", rd, 8'h00);
        bus_idle();
        check("err_tdr", tdr_v[0], 32'h005A_0000);
        check("err_tcr", tcr_v[0], 32'h0000_B300);
        check("err_tsr", tsr_v[0], 32'h0000_0001);
        check("err_tdr_wr", tdr_wr_v[0], 4'b0000);

        apb(0, 8'h00, 1'b1, 8'h11, rd, err, cyc);
        bus_idle();
        check("tdr0_wr", tdr_v[0][7:0], 8'h11);

        // Abort: PSEL falls while the transfer is in its wait cycle.
        @(negedge PCLK);
        psel_v[0] = 1'b1; penable_v[0] = 1'b0; PADDR = 8'h00; PWRITE = 1'b1; PWDATA = 8'h77;
        @(negedge PCLK);
        psel_v[0] = 1'b0;
        seen_rdy = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            seen_rdy = seen_rdy | pready_v[0];
        end
        check("abort_noready", seen_rdy, 1'b0);
        check("abort_tdr", tdr_v[0][7:0], 8'h11);
        apb(0, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("abort_rd", rd, 8'h11);
        check("abort_cyc", cyc, 3);

        apb(1, 8'h04, 1'b1, 8'hC4, rd, err, cyc);
        check("ws0_cyc", cyc, 2);
        bus_idle();
        check("ws0_tdr", tdr_v[1][15:8], 8'hC4);
        apb(2, 8'h04, 1'b1, 8'h3C, rd, err, cyc);
        check("ws3_cyc", cyc, 5);
        apb(2, 8'h04, 1'b0, 8'h00, rd, err, cyc);
        check("ws3_rd", rd, 8'h3C);
        check("ws3_rd_cyc", cyc, 5);

        // Reset in the middle of a write to TDR0.
        bus_idle();
        @(negedge PCLK);
        psel_v[0] = 1'b1; penable_v[0] = 1'b0; PADDR = 8'h00; PWRITE = 1'b1; PWDATA = 8'h77;
        @(negedge PCLK);
        penable_v[0] = 1'b1;
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0; psel_v = '0; penable_v = '0; PWRITE = 1'b0;
        check("rstmid_tdr", tdr_v[0][7:0], 8'h00);
        check("rstmid_ready", pready_v[0], 1'b0);
        @(negedge PCLK);
        check("rstmid_tdr_after", tdr_v[0][7:0], 8'h00);
        check("rstmid_tdr_wr", tdr_wr_v[0], 4'b0000);
        apb(0, 8'h00, 1'b0, 8'h00, rd, err, cyc);
        check("rstmid_cyc", cyc, 3);
        check("rstmid_rd", rd, 8'h00);
        bus_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_timer_regs.md
# apb_timer_regs

Parametrised APB slave register block for the multi-channel timer: holds per-channel TDR/TCR/TSR, adds programmable wait states, write-1-to-clear status with hardware set inputs, and address/decode error reporting. Sits between the APB bus and NUM_CH timer counter cores. It generalises the single-channel read/write control to N channels.

## Interface
- ADDR_WIDTH, 8, APB address width
- DATA_WIDTH, 8, register/data width (≥ 8)
- NUM_CH, 4, timer channels (1..16; NUM_CH*4 ≤ 2^ADDR_WIDTH)
- WAIT_STATES, 1, access-phase cycles with PREADY low before completion (0..15)
- TCR_MASK, 8'hB3, writable TCR bits; other bits read 0
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer completion
- PSLVERR  out  1  transfer error, valid with PREADY
- TDR, TCR, TSR  out  NUM_CH*DATA_WIDTH each  channel c in bits [c*DATA_WIDTH +: DATA_WIDTH]
- tdr_wr  out  NUM_CH  one-cycle pulse after a committed TDR write
- tsr_set  in  2*NUM_CH  per channel {udf, ovf} hardware set strobes

## Operation
- Map: channel c base = 4*c; offset 0 TDR (RW), 1 TCR (RW, masked by TCR_MASK), 2 TSR (bit0 OVF, bit1 UDF, W1C; other bits 0), 3 reserved.
- Invalid: offset 3, or address ≥ 4*NUM_CH, or write to TSR with no valid bit set is NOT an error (W1C of 0 is a no-op).
- FSM states IDLE, WAIT, READY.
- IDLE → WAIT on PSEL & !PENABLE (setup), counter loaded with WAIT_STATES; if WAIT_STATES=0, IDLE → READY directly.
- WAIT: decrement each cycle while PSEL; at count 1 → READY. PSEL low in WAIT → IDLE, no side effects (abort).
- READY: PREADY=1 for exactly one cycle; write commits at this edge if PSEL&PENABLE&PWRITE and no error; → IDLE.
- Reads: PRDATA = addressed register while in READY, 0 otherwise and on error.
- TSR update per bit: next = tsr_set | (cur & ~(wr_commit ? PWDATA : 0)); hardware set wins over simultaneous software clear.
- tdr_wr[c] high the cycle after a committed TDR write to channel c.
- Back-to-back transfers allowed: new setup may follow the READY cycle immediately.

## Timing
- Reset (PRESET=1 at edge): FSM IDLE, counter 0, all TDR/TCR/TSR = 0, PRDATA=0, PREADY=0, PSLVERR=0, tdr_wr=0. Reset mid-transfer discards the transfer.
- Outputs registered/state-decoded; no combinational PADDR→PRDATA path.
- Latency: setup edge → PREADY after WAIT_STATES+1 access cycles; total transfer = WAIT_STATES+2 cycles.
- Register outputs TDR/TCR/TSR update at the commit edge; tsr_set reflected in TSR one cycle after assertion.

## Configuration
- APB_PSLVERR_EN defined: invalid accesses complete with PSLVERR=1 in READY, writes dropped, PRDATA=0.
- Undefined: PSLVERR tied 0; invalid writes silently dropped, invalid reads return 0; timing unchanged.

## Structure
- Package timer_regs_pkg: offset constants (OFS_TDR=0, OFS_TCR=1, OFS_TSR=2), TSR bit indices (TSR_OVF=0, TSR_UDF=1), FSM state enum.
- One sub-module: timer_ch_regs (one channel's TDR/TCR/TSR, mask and W1C logic), instantiated NUM_CH times via generate; top holds FSM, wait counter, decode, read mux.

## Test plan
- Reset then read addr 0x01 (WAIT_STATES=1) → PREADY high 3rd cycle after setup, PRDATA=0x00, PSLVERR=0.
- Write 0xFF to 0x05 (ch1 TCR) then read → TCR[15:8]=0xB3, PRDATA=0xB3; write 0x5A to 0x08 → TDR[23:16]=0x5A, tdr_wr=4'b0100 for one cycle.
- Pulse tsr_set ch0 ovf, read 0x02 → 0x01; write 0x01 to 0x02 → TSR[7:0]=0x00; same-cycle set and clear → stays 0x01.
- Access 0x03 and 0x10 with APB_PSLVERR_EN → PSLVERR=1, no register change; without macro → PSLVERR=0, read 0x00.
- WAIT_STATES=0 and 3 → PREADY one cycle after PENABLE rises vs four cycles.
- Drop PSEL during WAIT, or assert PRESET mid-write of 0x77 to 0x00 → TDR[7:0] remains prior value / 0x00, FSM IDLE.
